// File: rtl/ysyx_bus_arbiter_if.sv
// Downstream memory bus: AXI-lite-like read channel plus a single combined
// write address+data channel. The master side is the arbiter, the slave side is memory.
interface ysyx_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, wready, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, wready, bvalid
    );
endinterface

// File: rtl/ysyx_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the IFU fetch port and
// the LSU load/store port; one bus transaction in flight, done returned as a pulse.
module ysyx_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit PRIO_RST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_ren,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_done,
    ysyx_bus_arbiter_if.master  bus
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 1 = LSU owns the current transaction
    logic                prio_q, prio_d;     // 1 = LSU wins a tie
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

    logic ifu_req, lsu_req, grant_ifu, grant_lsu;

    assign ifu_req   = ifu_arvalid;
    assign lsu_req   = lsu_ren | lsu_wen;
    assign grant_lsu = lsu_req & (~ifu_req | prio_q);
    assign grant_ifu = ifu_req & (~lsu_req | ~prio_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= 1'b0;
            prio_q  <= PRIO_RST;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            owner_q <= owner_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Requests are only sampled in IDLE; the winner's payload is frozen into
    // the registers so the requester may change its inputs afterwards.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: begin
                if (grant_lsu) begin
                    state_d = lsu_wen ? WR : RD_A;
                    owner_d = 1'b1;
                    prio_d  = 1'b0;
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    wstrb_d = lsu_wstrb;
                end else if (grant_ifu) begin
                    state_d = RD_A;
                    owner_d = 1'b0;
                    prio_d  = 1'b1;
                    addr_d  = ifu_araddr;
                end
            end
            RD_A:    if (bus.arready) state_d = RD_D;
            RD_D:    if (bus.rvalid)  state_d = IDLE;
            WR:      if (bus.wready)  state_d = WR_B;
            WR_B:    if (bus.bvalid)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.arvalid = (state_q == RD_A);
        bus.rready  = (state_q == RD_D);
        bus.wvalid  = (state_q == WR);
        bus.bready  = (state_q == WR_B);
        ifu_rvalid  = (state_q == RD_D) & bus.rvalid & ~owner_q;
        lsu_done    = owner_q & (((state_q == RD_D) & bus.rvalid) |
                                 ((state_q == WR_B) & bus.bvalid));
    end

    assign bus.araddr = addr_q;
    assign bus.awaddr = addr_q;
    assign bus.wdata  = wdata_q;
    assign bus.wstrb  = wstrb_q;
    assign ifu_rdata  = bus.rdata;
    assign lsu_rdata  = bus.rdata;

endmodule

// File: tb/tb_ysyx_bus_arbiter.sv
// Scoreboard bench for ysyx_bus_arbiter: directed requests push expected bus
// handshakes and done pulses; a monitor pops and compares as the DUT presents them.
module tb_ysyx_bus_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct packed {
        logic        lsu;
        logic        chk;
        logic [31:0] data;
    } done_t;

    logic        clk, rst;
    logic [31:0] ifu_araddr, ifu_rdata, lsu_addr, lsu_wdata, lsu_rdata;
    logic        ifu_arvalid, ifu_rvalid, lsu_ren, lsu_wen, lsu_done;
    logic [3:0]  lsu_wstrb;

    ysyx_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_RST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_addr(lsu_addr), .lsu_ren(lsu_ren), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
        .bus(bus)
    );

    int checks = 0, errors = 0;
    int ar_wait = 0, r_wait = 0, w_wait = 0, b_wait = 0;
    int ifu_dn = 0, lsu_dn = 0, wv_cycles = 0;
    bus_t  exp_bus[$];
    done_t exp_done[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_model(logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    task automatic push_rd(logic [31:0] a);
        bus_t e;
        e.wr = 1'b0; e.addr = a; e.wdata = 32'h0; e.wstrb = 4'h0;
        exp_bus.push_back(e);
    endtask

    task automatic push_wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        bus_t e;
        e.wr = 1'b1; e.addr = a; e.wdata = d; e.wstrb = s;
        exp_bus.push_back(e);
    endtask

    task automatic push_done(logic lsu, logic c, logic [31:0] d);
        done_t e;
        e.lsu = lsu; e.chk = c; e.data = d;
        exp_done.push_back(e);
    endtask

    task automatic step;
        @(negedge clk);
        #2;
    endtask

    // Memory slave: readies/responses after the configured number of wait cycles.
    initial begin
        int ar_cnt, r_cnt, w_cnt, b_cnt;
        ar_cnt = 0; r_cnt = 0; w_cnt = 0; b_cnt = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
        bus.wready = 1'b0; bus.bvalid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_wait); ar_cnt++; end
            else begin bus.arready = 1'b0; ar_cnt = 0; end
            if (bus.rready) begin bus.rvalid = (r_cnt >= r_wait); r_cnt++; end
            else begin bus.rvalid = 1'b0; r_cnt = 0; end
            bus.rdata = bus.rvalid ? rd_model(bus.araddr) : 32'h0;
            if (bus.wvalid) begin bus.wready = (w_cnt >= w_wait); w_cnt++; end
            else begin bus.wready = 1'b0; w_cnt = 0; end
            if (bus.bready) begin bus.bvalid = (b_cnt >= b_wait); b_cnt++; end
            else begin bus.bvalid = 1'b0; b_cnt = 0; end
        end
    end

    // Monitor: pops expectations on every handshake and done pulse.
    initial begin
        logic        ar_hold, w_hold;
        logic [31:0] ar_prev, aw_prev, wd_prev;
        logic [3:0]  ws_prev;
        bus_t  eb;
        done_t ed;
        ar_hold = 1'b0; w_hold = 1'b0;
        ar_prev = 32'h0; aw_prev = 32'h0; wd_prev = 32'h0; ws_prev = 4'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                ar_hold = 1'b0;
                w_hold  = 1'b0;
            end else begin
                if (bus.arvalid && ar_hold) chk("araddr_stable", 64'(bus.araddr), 64'(ar_prev));
                if (bus.wvalid && w_hold) begin
                    chk("wpayload_stable", {bus.awaddr, bus.wdata}, {aw_prev, wd_prev});
                    chk("wstrb_stable", 64'(bus.wstrb), 64'(ws_prev));
                end
                ar_hold = bus.arvalid && !bus.arready;
                w_hold  = bus.wvalid && !bus.wready;
                ar_prev = bus.araddr;
                aw_prev = bus.awaddr; wd_prev = bus.wdata; ws_prev = bus.wstrb;
                if (bus.wvalid) wv_cycles++;
                if (bus.arvalid && bus.arready) begin
                    if (exp_bus.size() == 0) fail("unexpected_read");
                    else begin
                        eb = exp_bus.pop_front();
                        chk("ar_is_read", 64'(eb.wr), 64'd0);
                        chk("araddr", 64'(bus.araddr), 64'(eb.addr));
                    end
                end
                if (bus.wvalid && bus.wready) begin
                    if (exp_bus.size() == 0) fail("unexpected_write");
                    else begin
                        eb = exp_bus.pop_front();
                        chk("w_is_write", 64'(eb.wr), 64'd1);
                        chk("awaddr", 64'(bus.awaddr), 64'(eb.addr));
                        chk("wdata", 64'(bus.wdata), 64'(eb.wdata));
                        chk("wstrb", 64'(bus.wstrb), 64'(eb.wstrb));
                    end
                end
                if (ifu_rvalid || lsu_done) begin
                    chk("done_exclusive", 64'(ifu_rvalid & lsu_done), 64'd0);
                    if (lsu_done) lsu_dn++;
                    if (ifu_rvalid) ifu_dn++;
                    if (exp_done.size() == 0) fail("unexpected_done");
                    else begin
                        ed = exp_done.pop_front();
                        chk("done_owner", 64'(lsu_done), 64'(ed.lsu));
                        if (ed.chk) chk("done_rdata", 64'(ed.lsu ? lsu_rdata : ifu_rdata), 64'(ed.data));
                    end
                end
            end
        end
    end

    task automatic do_reset;
        chk("queues_drained", 64'(exp_bus.size() + exp_done.size()), 64'd0);
        ifu_arvalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
        ar_wait = 0; r_wait = 0; w_wait = 0; b_wait = 0;
        rst = 1'b0;
        #1;
        chk("rst_valids", 64'({bus.arvalid, bus.rready, bus.wvalid, bus.bready, ifu_rvalid, lsu_done}), 64'd0);
        chk("rst_addr", {bus.araddr, bus.awaddr}, 64'd0);
        chk("rst_wdata", 64'({bus.wstrb, bus.wdata}), 64'd0);
        step;
        step;
        rst = 1'b1;
        ifu_dn = 0; lsu_dn = 0; wv_cycles = 0;
        step;
    endtask

    // Requesters drop their request in the cycle of their own done pulse.
    task automatic run_until_idle(int budget);
        for (int i = 0; i < budget; i++) begin
            step;
            if (ifu_rvalid) ifu_arvalid = 1'b0;
            if (lsu_done) begin lsu_ren = 1'b0; lsu_wen = 1'b0; end
            if (!ifu_arvalid && !lsu_ren && !lsu_wen) return;
        end
        fail("run_until_idle_timeout");
    endtask

    task automatic ifu_read_timed(logic [31:0] a);
        push_rd(a);
        push_done(1'b0, 1'b1, rd_model(a));
        ifu_araddr = a; ifu_arvalid = 1'b1;
        step;
        chk("arvalid_at_n1", 64'(bus.arvalid), 64'd1);
        chk("araddr_at_n1", 64'(bus.araddr), 64'(a));
        step;
        chk("ifu_rvalid_at_n2", 64'(ifu_rvalid), 64'd1);
        ifu_arvalid = 1'b0;
        step;
        chk("ifu_rvalid_one_cycle", 64'(ifu_rvalid), 64'd0);
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit;
        rst = 1'b1;
        ifu_arvalid = 1'b0; ifu_araddr = 32'h0;
        lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wstrb = 4'h0;
        #3;
        do_reset;

        // 1: IFU-only read, zero-wait slave.
        ifu_read_timed(32'h8000_0000);
        step;
        chk("t1_no_lsu_done", 64'(lsu_dn), 64'd0);

        // 2: simultaneous requests after reset, LSU has priority.
        do_reset;
        push_rd(32'h8000_2000); push_done(1'b1, 1'b1, rd_model(32'h8000_2000));
        push_rd(32'h8000_0004); push_done(1'b0, 1'b1, rd_model(32'h8000_0004));
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        lsu_addr = 32'h8000_2000; lsu_ren = 1'b1;
        run_until_idle(40);

        // 3: LSU write, wready 3 cycles late, bvalid 2 cycles after that.
        do_reset;
        w_wait = 3; b_wait = 1;
        push_wr(32'h8000_1000, 32'hDEAD_BEEF, 4'hF); push_done(1'b1, 1'b0, 32'h0);
        lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wen = 1'b1;
        step;
        lsu_wdata = 32'h0; lsu_addr = 32'h0; lsu_wstrb = 4'h0;
        run_until_idle(40);
        chk("t3_wvalid_cycles", 64'(wv_cycles), 64'd4);
        chk("t3_lsu_done_count", 64'(lsu_dn), 64'd1);

        // 4: both request continuously; strict LSU/IFU alternation.
        do_reset;
        for (int k = 0; k < 5; k++) begin
            push_wr(32'h8000_3000, 32'h1234_5678, 4'h3); push_done(1'b1, 1'b0, 32'h0);
            push_rd(32'h8000_0100); push_done(1'b0, 1'b1, rd_model(32'h8000_0100));
        end
        lsu_addr = 32'h8000_3000; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3; lsu_wen = 1'b1;
        ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step;
            if (ifu_dn + lsu_dn >= 10) begin
                hit = 1'b1;
                ifu_arvalid = 1'b0; lsu_wen = 1'b0;
            end
        end
        if (!hit) fail("t4_timeout");
        chk("t4_ifu_dones", 64'(ifu_dn), 64'd5);
        chk("t4_lsu_dones", 64'(lsu_dn), 64'd5);
        step; step;

        // 5: reset while in RD_D abandons the read.
        do_reset;
        r_wait = 6;
        push_rd(32'h8000_0008);
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step;
            hit = bus.rready;
        end
        if (!hit) fail("t5_no_rd_d");
        step;
        rst = 1'b0;
        #1;
        chk("t5_valids_async", 64'({bus.arvalid, bus.rready, bus.wvalid, bus.bready, ifu_rvalid, lsu_done}), 64'd0);
        chk("t5_addr_async", 64'(bus.araddr), 64'd0);
        ifu_arvalid = 1'b0;
        step; step;
        rst = 1'b1;
        r_wait = 0;
        ifu_dn = 0;
        step;
        chk("t5_no_ifu_done", 64'(ifu_dn), 64'd0);
        ifu_read_timed(32'h8000_000C);

        // 6: IFU changes its address after grant; captured address holds.
        do_reset;
        ar_wait = 2; r_wait = 1;
        push_rd(32'h8000_0000); push_done(1'b0, 1'b1, 32'h0000_0413);
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        step;
        ifu_araddr = 32'h8000_0040;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            chk("t6_araddr_held", 64'(bus.araddr), 64'h8000_0000);
            if (ifu_rvalid) begin hit = 1'b1; ifu_arvalid = 1'b0; end
            else step;
        end
        if (!hit) fail("t6_timeout");

        // 7: ren and wen together is serviced as a write.
        do_reset;
        push_wr(32'h8000_4000, 32'hCAFE_F00D, 4'hC); push_done(1'b1, 1'b0, 32'h0);
        lsu_addr = 32'h8000_4000; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hC;
        lsu_ren = 1'b1; lsu_wen = 1'b1;
        run_until_idle(30);

        // 8: LSU request withdrawn before grant produces no bus activity.
        do_reset;
        r_wait = 3;
        push_rd(32'h8000_0010); push_done(1'b0, 1'b1, rd_model(32'h8000_0010));
        ifu_araddr = 32'h8000_0010; ifu_arvalid = 1'b1;
        step;
        lsu_addr = 32'h8000_5000; lsu_ren = 1'b1;
        step;
        lsu_ren = 1'b0;
        run_until_idle(30);
        step; step;
        chk("t8_no_lsu_done", 64'(lsu_dn), 64'd0);

        do_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
